// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared constants and the Tnew countdown helper for pipe_stage_reg.
//   RESET_PC_DEFAULT  PC loaded at reset and by a non-PC-keeping bubble
//   NOP_IR            instruction word of a bubble
//   EXC_NONE          "no exception" code
//   TNEW_W_DEFAULT    default Tnew field width
//   tnew_next(t)      Tnew as seen one stage later, saturating at 0
package pipe_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_IR = 32'h0;
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam int TNEW_W_DEFAULT = 3;
    function automatic logic [31:0] tnew_next(input logic [31:0] t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: stage-boundary bundle between an upstream and a downstream stage.
//   control : en (load), flush (bubble)
//   inputs  : ir_i, pc_i, data_i (NUM_DATA x 32 lanes), grf_we_i, tnew_i, exc_code_i, bd_i
//   outputs : ir_o, pc_o, pc4_o, pc8_o, data_o, grf_we_o, tnew_o, valid_o, exc_code_o, bd_o, hold_cnt_o
//   master drives control/inputs and reads outputs; slave is the register itself.
interface pipe_stage_reg_if import pipe_pkg::*; #(
    parameter int NUM_DATA = 3,
    parameter int TNEW_W = TNEW_W_DEFAULT,
    parameter int HOLD_W = 4
);
    logic                  en;
    logic                  flush;
    logic [31:0]           ir_i;
    logic [31:0]           pc_i;
    logic [32*NUM_DATA-1:0] data_i;
    logic                  grf_we_i;
    logic [TNEW_W-1:0]     tnew_i;
    logic [4:0]            exc_code_i;
    logic                  bd_i;
    logic [31:0]           ir_o;
    logic [31:0]           pc_o;
    logic [31:0]           pc4_o;
    logic [31:0]           pc8_o;
    logic [32*NUM_DATA-1:0] data_o;
    logic                  grf_we_o;
    logic [TNEW_W-1:0]     tnew_o;
    logic                  valid_o;
    logic [4:0]            exc_code_o;
    logic                  bd_o;
    logic [HOLD_W-1:0]     hold_cnt_o;

    modport master (
        output en, flush, ir_i, pc_i, data_i, grf_we_i, tnew_i, exc_code_i, bd_i,
        input  ir_o, pc_o, pc4_o, pc8_o, data_o, grf_we_o, tnew_o, valid_o, exc_code_o, bd_o, hold_cnt_o
    );
    modport slave (
        input  en, flush, ir_i, pc_i, data_i, grf_we_i, tnew_i, exc_code_i, bd_i,
        output ir_o, pc_o, pc4_o, pc8_o, data_o, grf_we_o, tnew_o, valid_o, exc_code_o, bd_o, hold_cnt_o
    );
endinterface

// File: rtl/pipe_stage_reg_lane.sv
// pipe_lane_reg: one 32-bit data lane with async active-low reset, clear and load.
//   clk, reset (active low, async), ld (load d), clr (zero, beats ld), d in, q out
module pipe_lane_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic        clr,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else if (clr) q <= '0;
        else if (ld) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with load/hold/flush and stall diagnostics.
//   clk   rising-edge clock
//   reset asynchronous active-low reset
//   bus   pipe_stage_reg_if.slave: en/flush control, *_i payload in, *_o registered payload out,
//         valid_o (0 = bubble), hold_cnt_o (saturating count of cycles held with valid contents)
//   Edge priority: flush > en > hold.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int          NUM_DATA = 3,
    parameter int          TNEW_W = TNEW_W_DEFAULT,
    parameter int          HOLD_W = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1
) (
    input logic            clk,
    input logic            reset,
    pipe_stage_reg_if.slave bus
);
    logic [31:0]            ir_q, pc_q, pc4_q, pc8_q;
    logic                   we_q, valid_q, bd_q;
    logic [TNEW_W-1:0]      tnew_q;
    logic [4:0]             exc_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [31:0]            lane_q [NUM_DATA];
    logic [32*NUM_DATA-1:0] data_q;
    logic [31:0]            pc_src;
    logic                   bd_src, exc_hit;
    logic [TNEW_W-1:0]      tnew_ld;

    for (genvar k = 0; k < NUM_DATA; k++) begin : g_lane
        pipe_lane_reg u_lane (
            .clk   (clk),
            .reset (reset),
            .ld    (bus.en),
            .clr   (bus.flush),
            .d     (bus.data_i[32*k +: 32]),
            .q     (lane_q[k])
        );
    end

    always_comb begin
        data_q = '0;
        for (int i = 0; i < NUM_DATA; i++) data_q[32*i +: 32] = lane_q[i];
    end

    // A bubble either keeps the incoming PC/bd (so EPC can be recovered) or falls back to reset values.
    assign pc_src  = (bus.flush && !KEEP_PC_ON_FLUSH) ? RESET_PC : bus.pc_i;
    assign bd_src  = (bus.flush && !KEEP_PC_ON_FLUSH) ? 1'b0 : bus.bd_i;
    // A faulting instruction never writes back, so it must not stall consumers either.
    assign exc_hit = bus.exc_code_i != EXC_NONE;
    assign tnew_ld = exc_hit ? '0 : TNEW_W'(tnew_next(32'(bus.tnew_i)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q    <= NOP_IR;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + 32'd4;
            pc8_q   <= RESET_PC + 32'd8;
            we_q    <= 1'b0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
            exc_q   <= EXC_NONE;
            bd_q    <= 1'b0;
            hold_q  <= '0;
        end else if (bus.flush || bus.en) begin
            ir_q    <= bus.flush ? NOP_IR : bus.ir_i;
            pc_q    <= pc_src;
            pc4_q   <= pc_src + 32'd4;
            pc8_q   <= pc_src + 32'd8;
            we_q    <= !bus.flush && bus.grf_we_i && !exc_hit;
            tnew_q  <= bus.flush ? '0 : tnew_ld;
            valid_q <= !bus.flush;
            exc_q   <= bus.flush ? EXC_NONE : bus.exc_code_i;
            bd_q    <= bd_src;
            hold_q  <= '0;
        end else if (valid_q && hold_q != '1) begin
            hold_q  <= hold_q + 1'b1;
        end
    end

    assign bus.ir_o       = ir_q;
    assign bus.pc_o       = pc_q;
    assign bus.pc4_o      = pc4_q;
    assign bus.pc8_o      = pc8_q;
    assign bus.data_o     = data_q;
    assign bus.grf_we_o   = we_q;
    assign bus.tnew_o     = tnew_q;
    assign bus.valid_o    = valid_q;
    assign bus.exc_code_o = exc_q;
    assign bus.bd_o       = bd_q;
    assign bus.hold_cnt_o = hold_q;
endmodule
